// File: rtl/albacore_pkg.sv
// Shared constants for the albacore memory responder: data width, MMIO offsets, STATUS bits.
package albacore_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned BUS_ADDR_W = 16;
    localparam int unsigned MMIO_OFF_W = 4;

    localparam logic [MMIO_OFF_W-1:0] MMIO_STATUS   = 4'd0;
    localparam logic [MMIO_OFF_W-1:0] MMIO_IN_DATA  = 4'd1;
    localparam logic [MMIO_OFF_W-1:0] MMIO_OUT_DATA = 4'd2;
    localparam logic [MMIO_OFF_W-1:0] MMIO_TIMER    = 4'd3;

    localparam int unsigned STAT_IN_AVAIL = 0;
    localparam int unsigned STAT_OUT_FULL = 1;
    localparam int unsigned STAT_OVERFLOW = 2;

endpackage

// File: rtl/albacore_ram.sv
// Single-port word RAM with registered read; a same-cycle write returns the old word.
module albacore_ram #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage array carries no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/albacore_mem_responder.sv
// Memory-side responder: word RAM plus a 16-word MMIO window (status, input, output, timer).
// Optional cycle timer at MMIO offset 3 is built when ALBACORE_MMIO_TIMER_EN is defined.
module albacore_mem_responder #(
    parameter int unsigned DATA_W    = albacore_pkg::DATA_W,
    parameter int unsigned ADDR_W    = 12,
    parameter logic [15:0] MMIO_BASE = 16'hFFF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we_mem,
    input  logic              rd_take,
    output logic [DATA_W-1:0] rdata,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    import albacore_pkg::*;

    logic                  is_mmio;
    logic [MMIO_OFF_W-1:0] mmio_off;
    logic                  ram_we;
    logic [DATA_W-1:0]     ram_rdata;

    logic                  in_avail_q, in_avail_d;
    logic                  in_ready_q, in_ready_d;
    logic [DATA_W-1:0]     in_hold_q, in_hold_d;
    logic                  out_full_q, out_full_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_W-1:0]     mmio_rd_q, mmio_rd_d;
    logic                  is_mmio_q;

    logic wr_status, wr_out, wr_timer, push, pop, drain;

    assign is_mmio  = (addr >= MMIO_BASE);
    assign mmio_off = MMIO_OFF_W'(addr - MMIO_BASE);
    assign ram_we   = we_mem && !is_mmio;

    assign wr_status = we_mem && is_mmio && (mmio_off == MMIO_STATUS);
    assign wr_out    = we_mem && is_mmio && (mmio_off == MMIO_OUT_DATA);
    assign wr_timer  = we_mem && is_mmio && (mmio_off == MMIO_TIMER);
    assign push      = in_valid && in_ready_q;
    assign pop       = rd_take && is_mmio && (mmio_off == MMIO_IN_DATA) && in_avail_q;
    assign drain     = out_full_q && out_ready;

    albacore_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .addr_i  (addr[ADDR_W-1:0]),
        .wdata_i (wdata),
        .rdata_o (ram_rdata)
    );

`ifdef ALBACORE_MMIO_TIMER_EN
    logic [DATA_W-1:0] timer_q, timer_d;

    // A software load takes priority over the free-running increment.
    always_comb begin
        timer_d = timer_q + DATA_W'(1);
        if (wr_timer) begin
            timer_d = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_timer;
    assign unused_timer = wr_timer;
`endif

    // Next-state for the I/O flags and the registered MMIO read word.
    always_comb begin
        in_avail_d = in_avail_q;
        in_hold_d  = in_hold_q;
        out_full_d = out_full_q;
        out_data_d = out_data_q;
        overflow_d = overflow_q;
        mmio_rd_d  = '0;

        if (push) begin
            in_hold_d  = in_data;
            in_avail_d = 1'b1;
        end else if (pop) begin
            in_avail_d = 1'b0;
        end
        in_ready_d = !in_avail_d;

        // A write that lands on a draining buffer is accepted in place of the leaving word.
        if (wr_out) begin
            if (!out_full_q || drain) begin
                out_data_d = wdata;
                out_full_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (drain) begin
            out_full_d = 1'b0;
        end

        if (wr_status && wdata[STAT_OVERFLOW]) begin
            overflow_d = 1'b0;
        end

        case (mmio_off)
            MMIO_STATUS: begin
                mmio_rd_d[STAT_IN_AVAIL] = in_avail_q;
                mmio_rd_d[STAT_OUT_FULL] = out_full_q;
                mmio_rd_d[STAT_OVERFLOW] = overflow_q;
            end
            MMIO_IN_DATA:  mmio_rd_d = in_hold_q;
            MMIO_OUT_DATA: mmio_rd_d = out_data_q;
`ifdef ALBACORE_MMIO_TIMER_EN
            MMIO_TIMER:    mmio_rd_d = timer_q;
`endif
            default:       mmio_rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_avail_q <= 1'b0;
            in_ready_q <= 1'b1;
            in_hold_q  <= '0;
            out_full_q <= 1'b0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
            mmio_rd_q  <= '0;
            is_mmio_q  <= 1'b0;
        end else begin
            in_avail_q <= in_avail_d;
            in_ready_q <= in_ready_d;
            in_hold_q  <= in_hold_d;
            out_full_q <= out_full_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
            mmio_rd_q  <= mmio_rd_d;
            is_mmio_q  <= is_mmio;
        end
    end

    assign rdata     = is_mmio_q ? mmio_rd_q : ram_rdata;
    assign in_ready  = in_ready_q;
    assign out_valid = out_full_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_albacore_mem_responder.sv
// Randomized bench for albacore_mem_responder against a cycle-level behavioural model.
// Honours ALBACORE_MMIO_TIMER_EN the same way as the design.
module tb_albacore_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we_mem;
    logic        rd_take;
    logic [15:0] rdata;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    albacore_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .we_mem    (we_mem),
        .rd_take   (rd_take),
        .rdata     (rdata),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a word array, the I/O flags and the timer.
    logic [15:0] m_mem   [4096];
    bit          m_known [4096];
    bit          m_in_avail, m_out_full, m_ovf;
    logic [15:0] m_in_hold, m_out_data, m_timer;
    logic [15:0] m_rdata;
    bit          m_rdata_known;

    function automatic void model_reset();
        m_in_avail    = 0;
        m_out_full    = 0;
        m_ovf         = 0;
        m_in_hold     = 16'h0;
        m_out_data    = 16'h0;
        m_timer       = 16'h0;
        m_rdata       = 16'h0;
        m_rdata_known = 1;
    endfunction

    // One clock cycle: drive inputs at negedge, advance the model, compare after the edge.
    task automatic cycle(input logic [15:0] a, input logic [15:0] wd, input bit we,
                         input bit take, input bit iv, input logic [15:0] id, input bit ordy);
        bit          mmio;
        int unsigned off;
        int unsigned ix;
        bit          drain;
        addr = a; wdata = wd; we_mem = we; rd_take = take;
        in_valid = iv; in_data = id; out_ready = ordy;

        mmio = (a >= 16'hFFF0);
        off  = int'(a) - 32'hFFF0;
        ix   = int'(a) % 4096;
        m_rdata_known = 1;
        if (!mmio) begin
            m_rdata       = m_mem[ix];
            m_rdata_known = m_known[ix];
        end else if (off == 0) m_rdata = {13'd0, m_ovf, m_out_full, m_in_avail};
        else if (off == 1)     m_rdata = m_in_hold;
        else if (off == 2)     m_rdata = m_out_data;
`ifdef ALBACORE_MMIO_TIMER_EN
        else if (off == 3)     m_rdata = m_timer;
`endif
        else                   m_rdata = 16'h0;

        drain = m_out_full && ordy;
        if (we && mmio && off == 2) begin
            if (!m_out_full || drain) begin
                m_out_data = wd;
                m_out_full = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (drain) begin
            m_out_full = 0;
        end
        if (we && mmio && off == 0 && wd[2]) m_ovf = 0;
        if (iv && !m_in_avail) begin
            m_in_hold  = id;
            m_in_avail = 1;
        end else if (take && mmio && off == 1 && m_in_avail) begin
            m_in_avail = 0;
        end
`ifdef ALBACORE_MMIO_TIMER_EN
        if (we && mmio && off == 3) m_timer = wd;
        else m_timer = m_timer + 16'd1;
`endif
        if (we && !mmio) begin
            m_mem[ix]   = wd;
            m_known[ix] = 1;
        end

        @(posedge clk);
        #1;
        if (m_rdata_known) check_eq("rdata", rdata, m_rdata);
        check_eq("in_ready", 16'(in_ready), 16'(!m_in_avail));
        check_eq("out_valid", 16'(out_valid), 16'(m_out_full));
        check_eq("out_data", out_data, m_out_data);
        @(negedge clk);
    endtask

    task automatic rd(input logic [15:0] a, input bit take);
        cycle(a, 16'h0, 0, take, 0, 16'h0, 0);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit ordy);
        cycle(a, d, 1, 0, 0, 16'h0, ordy);
    endtask

    // Asynchronous reset in the middle of a low clock phase.
    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_out_valid", 16'(out_valid), 16'h0);
        check_eq("rst_in_ready", 16'(in_ready), 16'h1);
        check_eq("rst_rdata", rdata, 16'h0);
        check_eq("rst_out_data", out_data, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] a;
        int unsigned sel;
        for (int i = 0; i < 4096; i++) m_known[i] = 0;
        addr = 16'h0; wdata = 16'h0; we_mem = 0; rd_take = 0;
        in_valid = 0; in_data = 16'h0; out_ready = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_rdata", rdata, 16'h0);
        check_eq("reset_in_ready", 16'(in_ready), 16'h1);
        check_eq("reset_out_valid", 16'(out_valid), 16'h0);
        check_eq("reset_out_data", out_data, 16'h0);
        rst = 1'b0;

        // RAM store, two-cycle read and upper-bit alias.
        wr(16'h0010, 16'h1234, 0);
        rd(16'h0010, 0);
        rd(16'h0010, 1);
        check_eq("tp_ram_read", rdata, 16'h1234);
        rd(16'h1010, 0);
        rd(16'h1010, 1);
        check_eq("tp_ram_alias", rdata, 16'h1234);

        // Input push, status, pop.
        cycle(16'h0000, 16'h0, 0, 0, 1, 16'h00AB, 0);
        check_eq("tp_in_ready_low", 16'(in_ready), 16'h0);
        rd(16'hFFF0, 0);
        rd(16'hFFF0, 1);
        check_eq("tp_status_in", rdata, 16'h0001);
        rd(16'hFFF1, 0);
        rd(16'hFFF1, 1);
        check_eq("tp_in_data", rdata, 16'h00AB);
        rd(16'hFFF0, 0);
        rd(16'hFFF0, 1);
        check_eq("tp_status_clear", rdata, 16'h0000);
        check_eq("tp_in_ready_high", 16'(in_ready), 16'h1);

        // Output overflow and clear.
        wr(16'hFFF2, 16'h0005, 0);
        wr(16'hFFF2, 16'h0006, 0);
        rd(16'hFFF0, 0);
        rd(16'hFFF0, 0);
        check_eq("tp_out_keep", out_data, 16'h0005);
        check_eq("tp_status_ovf", rdata, 16'h0006);
        wr(16'hFFF0, 16'h0004, 0);
        rd(16'hFFF0, 0);
        rd(16'hFFF0, 0);
        check_eq("tp_status_ovf_clr", rdata, 16'h0002);

        // Write coinciding with a drain.
        wr(16'hFFF2, 16'h0007, 1);
        check_eq("tp_drain_valid", 16'(out_valid), 16'h1);
        check_eq("tp_drain_data", out_data, 16'h0007);
        rd(16'hFFF0, 0);
        rd(16'hFFF0, 0);
        check_eq("tp_drain_no_ovf", rdata, 16'h0002);

        // Mid-transfer reset with both buffers occupied.
        cycle(16'h0000, 16'h0, 0, 0, 1, 16'h0055, 0);
        mid_reset();

        // Timer wrap (reads 0 throughout when the timer is not built).
        wr(16'hFFF3, 16'hFFFE, 0);
        rd(16'hFFF3, 0);
        rd(16'hFFF3, 0);
        rd(16'hFFF3, 0);
        check_eq("tp_timer_wrap", rdata, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5) a = {4'($urandom), 9'd0, 3'($urandom)};
            else         a = 16'hFFF0 | 16'($urandom_range(0, 15));
            cycle(a, 16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom), 16'($urandom), 1'($urandom));
            if (i == 1500) mid_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
